// File: rtl/dwt_level_packer.sv
// DWT level packer: Lo words are rescaled and packed into six-word groups, and Hi words are
// buffered in a show-ahead FIFO. Define DWT_LO_SAT_EN to saturate Lo words instead of wrapping.
module dwt_level_packer #(
    parameter int unsigned Y_W      = 25,
    parameter int unsigned X_W      = 16,
    parameter int unsigned LO_SHIFT = 9,
    parameter int unsigned HI_DEPTH = 16,
    parameter int unsigned HI_AW    = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic signed [Y_W-1:0] Hi_D_y_down,
    input  logic signed [Y_W-1:0] Lo_D_y_down,
    input  logic                  down_clk,
    output logic signed [X_W-1:0] lo_x_6k,
    output logic signed [X_W-1:0] lo_x_6k_1,
    output logic signed [X_W-1:0] lo_x_6k_2,
    output logic signed [X_W-1:0] lo_x_6k_3,
    output logic signed [X_W-1:0] lo_x_6k_4,
    output logic signed [X_W-1:0] lo_x_6k_5,
    output logic                  lo_pack_valid,
    output logic signed [Y_W-1:0] hi_out,
    output logic                  hi_out_valid,
    input  logic                  hi_out_ready,
    output logic [HI_AW:0]        hi_level,
    output logic                  hi_overflow
);

    // ------------------------------------------------------------------
    // Lo word conversion
    // ------------------------------------------------------------------
    logic signed [X_W-1:0] w_lo_conv;

`ifdef DWT_LO_SAT_EN
    localparam logic signed [Y_W-1:0] LoMax = {{(Y_W-X_W+1){1'b0}}, {(X_W-1){1'b1}}};
    localparam logic signed [Y_W-1:0] LoMin = {{(Y_W-X_W+1){1'b1}}, {(X_W-1){1'b0}}};

    logic signed [Y_W-1:0] w_lo_shr;

    assign w_lo_shr = Lo_D_y_down >>> LO_SHIFT;

    always_comb begin
        w_lo_conv = w_lo_shr[X_W-1:0];
        if (w_lo_shr > LoMax) begin
            w_lo_conv = {1'b0, {(X_W-1){1'b1}}};
        end else if (w_lo_shr < LoMin) begin
            w_lo_conv = {1'b1, {(X_W-1){1'b0}}};
        end
    end
`else
    assign w_lo_conv = X_W'(Lo_D_y_down >>> LO_SHIFT);
`endif

    // ------------------------------------------------------------------
    // Lo staging and group output
    // ------------------------------------------------------------------
    // Only five staging slots are stored; the sixth word goes straight to the output group.
    logic [2:0]            r_idx;
    logic signed [X_W-1:0] r_slot [5];
    logic signed [X_W-1:0] r_lo_x [6];
    logic                  r_pack_valid;
    logic                  w_group_done;

    assign w_group_done = down_clk && (r_idx == 3'd5);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idx        <= 3'd0;
            r_pack_valid <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                r_slot[i] <= '0;
            end
            for (int i = 0; i < 6; i++) begin
                r_lo_x[i] <= '0;
            end
        end else begin
            r_pack_valid <= w_group_done;
            if (down_clk) begin
                if (r_idx == 3'd5) begin
                    r_idx <= 3'd0;
                end else begin
                    r_idx         <= r_idx + 3'd1;
                    r_slot[r_idx] <= w_lo_conv;
                end
            end
            if (w_group_done) begin
                for (int i = 0; i < 5; i++) begin
                    r_lo_x[i] <= r_slot[i];
                end
                r_lo_x[5] <= w_lo_conv;
            end
        end
    end

    assign lo_x_6k       = r_lo_x[0];
    assign lo_x_6k_1     = r_lo_x[1];
    assign lo_x_6k_2     = r_lo_x[2];
    assign lo_x_6k_3     = r_lo_x[3];
    assign lo_x_6k_4     = r_lo_x[4];
    assign lo_x_6k_5     = r_lo_x[5];
    assign lo_pack_valid = r_pack_valid;

    // ------------------------------------------------------------------
    // Hi show-ahead FIFO
    // ------------------------------------------------------------------
    logic signed [Y_W-1:0] r_mem [HI_DEPTH];
    logic [HI_AW-1:0]      r_wr_ptr;
    logic [HI_AW-1:0]      r_rd_ptr;
    logic [HI_AW:0]        r_level;
    logic                  r_overflow;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == (HI_AW+1)'(HI_DEPTH));
    assign w_pop   = !w_empty && hi_out_ready;
    // When full, a simultaneous pop frees the head slot, which is also the write slot.
    assign w_push  = down_clk && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= Hi_D_y_down;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + HI_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + HI_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (HI_AW+1)'(1);
                2'b01:   r_level <= r_level - (HI_AW+1)'(1);
                default: r_level <= r_level;
            endcase
            if (down_clk && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign hi_out_valid = !w_empty;
    assign hi_out       = w_empty ? '0 : r_mem[r_rd_ptr];
    assign hi_level     = r_level;
    assign hi_overflow  = r_overflow;

endmodule

// File: tb/tb_dwt_level_packer.sv
// Self-checking bench for dwt_level_packer: default build plus a LO_SHIFT=0 instance to
// exercise narrowing; expectations follow DWT_LO_SAT_EN when it is defined.
module tb_dwt_level_packer;

    localparam int YW    = 25;
    localparam int XW    = 16;
    localparam int SH    = 9;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 down_clk = 1'b0;
    logic                 hi_out_ready = 1'b0;
    logic signed [YW-1:0] hi_in = '0;
    logic signed [YW-1:0] lo_in = '0;

    logic signed [XW-1:0] lo_x [2][6];
    logic                 lo_pv [2];
    logic signed [YW-1:0] hi_out [2];
    logic                 hi_valid [2];
    logic [AW:0]          hi_level [2];
    logic                 hi_ovf [2];

    always #5 clk = ~clk;

    dwt_level_packer #(
        .Y_W(YW), .X_W(XW), .LO_SHIFT(SH), .HI_DEPTH(DEPTH), .HI_AW(AW)
    ) u_dut (
        .clk(clk), .rstn(rstn), .Hi_D_y_down(hi_in), .Lo_D_y_down(lo_in),
        .down_clk(down_clk),
        .lo_x_6k(lo_x[0][0]), .lo_x_6k_1(lo_x[0][1]), .lo_x_6k_2(lo_x[0][2]),
        .lo_x_6k_3(lo_x[0][3]), .lo_x_6k_4(lo_x[0][4]), .lo_x_6k_5(lo_x[0][5]),
        .lo_pack_valid(lo_pv[0]), .hi_out(hi_out[0]), .hi_out_valid(hi_valid[0]),
        .hi_out_ready(hi_out_ready), .hi_level(hi_level[0]), .hi_overflow(hi_ovf[0])
    );

    dwt_level_packer #(
        .Y_W(YW), .X_W(XW), .LO_SHIFT(0), .HI_DEPTH(DEPTH), .HI_AW(AW)
    ) u_dut_ns (
        .clk(clk), .rstn(rstn), .Hi_D_y_down(hi_in), .Lo_D_y_down(lo_in),
        .down_clk(down_clk),
        .lo_x_6k(lo_x[1][0]), .lo_x_6k_1(lo_x[1][1]), .lo_x_6k_2(lo_x[1][2]),
        .lo_x_6k_3(lo_x[1][3]), .lo_x_6k_4(lo_x[1][4]), .lo_x_6k_5(lo_x[1][5]),
        .lo_pack_valid(lo_pv[1]), .hi_out(hi_out[1]), .hi_out_valid(hi_valid[1]),
        .hi_out_ready(hi_out_ready), .hi_level(hi_level[1]), .hi_overflow(hi_ovf[1])
    );

    // Reference model state
    int                   n_checks = 0;
    int                   n_fail = 0;
    longint               hist [2][$];
    longint               grp [2][6];
    bit                   exp_pv = 1'b0;
    bit                   exp_ovf = 1'b0;
    logic signed [YW-1:0] hq [$];

    function automatic longint conv(input logic signed [YW-1:0] lo, input int sh);
        longint v;
        longint lim_hi;
        longint lim_lo;
        v      = longint'(lo) >>> sh;
        lim_hi = (longint'(1) << (XW - 1)) - 1;
        lim_lo = -lim_hi - 1;
`ifdef DWT_LO_SAT_EN
        if (v > lim_hi) v = lim_hi;
        if (v < lim_lo) v = lim_lo;
`else
        v = v & ((longint'(1) << XW) - 1);
        if (v > lim_hi) v = v - (longint'(1) << XW);
`endif
        return v;
    endfunction

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d lo_pack_valid", d), longint'(lo_pv[d]), longint'(exp_pv));
            for (int i = 0; i < 6; i++) begin
                check_eq($sformatf("d%0d lo_x[%0d]", d, i), longint'(lo_x[d][i]), grp[d][i]);
            end
            check_eq($sformatf("d%0d hi_out_valid", d), longint'(hi_valid[d]),
                     longint'(hq.size() != 0));
            check_eq($sformatf("d%0d hi_out", d), longint'(hi_out[d]),
                     (hq.size() != 0) ? longint'(hq[0]) : 64'sd0);
            check_eq($sformatf("d%0d hi_level", d), longint'(hi_level[d]), longint'(hq.size()));
            check_eq($sformatf("d%0d hi_overflow", d), longint'(hi_ovf[d]), longint'(exp_ovf));
        end
    endtask

    // One clock: drive inputs, let the edge happen, update the model, compare.
    task automatic step(input bit s, input logic [YW-1:0] hi, input logic [YW-1:0] lo,
                        input bit rdy);
        int sz;
        bit pop;
        down_clk     = s;
        hi_in        = hi;
        lo_in        = lo;
        hi_out_ready = rdy;
        @(posedge clk);
        sz  = hq.size();
        pop = (sz > 0) && rdy;
        if (pop) void'(hq.pop_front());
        if (s) begin
            if (sz < DEPTH || pop) hq.push_back(hi);
            else exp_ovf = 1'b1;
        end
        exp_pv = 1'b0;
        if (s) begin
            for (int d = 0; d < 2; d++) begin
                hist[d].push_back(conv(lo, (d == 0) ? SH : 0));
                if (hist[d].size() == 6) begin
                    for (int i = 0; i < 6; i++) grp[d][i] = hist[d][i];
                    hist[d].delete();
                    exp_pv = 1'b1;
                end
            end
        end
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        down_clk     = 1'b0;
        hi_out_ready = 1'b0;
        #2 rstn = 1'b0;
        #1;
        hq.delete();
        for (int d = 0; d < 2; d++) begin
            hist[d].delete();
            for (int i = 0; i < 6; i++) grp[d][i] = 0;
        end
        exp_pv  = 1'b0;
        exp_ovf = 1'b0;
        compare_all();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, rdy);
    endtask

    logic [YW-1:0] edge_lo [6];

    initial begin
        edge_lo[0] = 25'h0FFFFFF;
        edge_lo[1] = 25'h1000000;
        edge_lo[2] = 25'h0000000;
        edge_lo[3] = 25'h1FFFFFF;
        edge_lo[4] = 25'h0012345;
        edge_lo[5] = 25'h1FF8000;

        // First group of six.
        do_reset();
        for (int k = 1; k <= 6; k++) step(1'b1, YW'(k), YW'(512 * k), 1'b0);
        idle(3, 1'b0);

        // Twelve back-to-back strobes: two groups, then hold.
        do_reset();
        for (int k = 1; k <= 12; k++) step(1'b1, YW'(k), YW'(512 * k), 1'b0);
        idle(4, 1'b0);

        // Narrowing boundary values.
        do_reset();
        for (int k = 0; k < 6; k++) step(1'b1, YW'(k), edge_lo[k], 1'b0);
        idle(2, 1'b1);

        // Overflow: 17 writes into a 16-deep FIFO, then drain.
        do_reset();
        for (int k = 1; k <= 17; k++) step(1'b1, YW'(k), '0, 1'b0);
        idle(18, 1'b1);

        // Full with simultaneous write and pop: no overflow.
        do_reset();
        for (int k = 1; k <= 16; k++) step(1'b1, YW'(k), '0, 1'b0);
        step(1'b1, YW'(100), '0, 1'b1);
        idle(18, 1'b1);

        // Reset mid-group with three words queued.
        do_reset();
        for (int k = 1; k <= 3; k++) step(1'b1, YW'(k), YW'(512 * 77), 1'b0);
        do_reset();
        for (int k = 1; k <= 6; k++) step(1'b1, YW'(k + 40), YW'(512 * k), 1'b0);
        idle(2, 1'b0);

        // Random traffic: slow consumer, then fast consumer.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), YW'($urandom), YW'($urandom),
                 ($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 2) != 0), YW'($urandom), YW'($urandom),
                 ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dwt_level_packer.md
Name: dwt_level_packer

Overview:
- Sits directly downstream of the DWT downsampler.
- Consumes the strobed, decimated Hi/Lo coefficient stream (one Hi and one Lo word per down_clk pulse).
- Lo path: rescales each Lo word to the next level's input width and packs six consecutive samples into a parallel 6-word group for the next-level polyphase FIR.
- Hi path: buffers Hi detail coefficients in a show-ahead FIFO with a valid/ready output handshake.

Parameters:
- Y_W, 25, width of incoming downsampled coefficients (signed).
- X_W, 16, width of each packed Lo output word (signed); next-level FIR input width.
- LO_SHIFT, 9, arithmetic right shift applied to Lo words before width reduction.
- HI_DEPTH, 16, Hi FIFO depth; must be a power of 2, >= 2.
- HI_AW, 4, log2(HI_DEPTH).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- Hi_D_y_down  in  Y_W  decimated Hi coefficient, signed.
- Lo_D_y_down  in  Y_W  decimated Lo coefficient, signed.
- down_clk  in  1  sample strobe; Hi_D_y_down and Lo_D_y_down are valid in any cycle it is high.
- lo_x_6k .. lo_x_6k_5  out  X_W each (6 ports)  packed Lo group; lo_x_6k is the oldest sample, lo_x_6k_5 the newest.
- lo_pack_valid  out  1  one-cycle pulse; the group is new.
- hi_out  out  Y_W  Hi FIFO head word.
- hi_out_valid  out  1  FIFO not empty.
- hi_out_ready  in  1  consumer accepts hi_out when hi_out_valid is also high.
- hi_level  out  HI_AW+1  current FIFO occupancy, 0..HI_DEPTH.
- hi_overflow  out  1  sticky; set when a Hi word was dropped.

Behaviour:
- Reset (rstn low, asynchronous):
  - All lo_x_* = 0, lo_pack_valid = 0, slot index = 0.
  - FIFO pointers = 0, hi_level = 0, hi_out_valid = 0, hi_overflow = 0.
  - hi_out = 0 while the FIFO is empty.
  - Reset mid-group discards any partial Lo group and all FIFO contents.
- Lo conversion: v = Lo_D_y_down >>> LO_SHIFT (arithmetic). Narrowing to X_W is defined under Optional Feature.
- Lo collection:
  - 6 internal staging slots and a 3-bit index idx, 0..5.
  - On a clock edge with down_clk high: slot[idx] <= converted v.
  - idx increments, wrapping 5 -> 0.
- Lo group output:
  - On the edge where idx==5 is written, all six values (slots 0..4 plus the current word into position 5) load the lo_x_* output registers.
  - lo_pack_valid is high for exactly the following cycle. Latency: 1 cycle from the 6th strobe edge.
  - lo_x_* hold their value until the next group completes. Staging continues immediately, so back-to-back strobes lose no samples.
  - When down_clk is low, idx and slots hold.
- Hi FIFO:
  - Write when down_clk is high. Read (pop) when hi_out_valid && hi_out_ready.
  - Show-ahead: hi_out = memory[rd_ptr] whenever hi_out_valid is high.
  - No write-to-read bypass: a word written at edge N into an empty FIFO is visible, with hi_out_valid=1, in the cycle after edge N.
  - Full, write, no pop: word dropped, hi_overflow <= 1 (sticky until reset), hi_level stays HI_DEPTH.
  - Full, write, pop in the same cycle: both occur, level unchanged, no overflow.
  - Empty, pop attempted: impossible because hi_out_valid=0, so ready is ignored.
  - Pointers are HI_AW bits and wrap naturally. hi_level updates with +1, -1 or 0 per edge.
- No combinational path from any input to any output except hi_out_valid/hi_out, which are driven from registered pointers and memory only.

Optional Feature:
- Macro: DWT_LO_SAT_EN.
- Defined: the shifted value v saturates to [-2^(X_W-1), 2^(X_W-1)-1] before packing.
- Undefined: v is truncated to its low X_W bits (two's-complement wrap).
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then 6 strobes, Lo = 512*k for k = 1..6 -> one lo_pack_valid pulse one cycle after the 6th strobe; lo_x_6k..lo_x_6k_5 = 1..6; no pulse after strobes 1-5.
- 12 back-to-back strobes, then idle -> exactly 2 pulses, 6 cycles apart; the second group holds samples 7..12; outputs hold after idle.
- Lo = 0x0FFFFFF (2^24-1): with DWT_LO_SAT_EN -> 32767; without -> low 16 bits of 32767... shifted value 32767 fits, so also use Lo = -2^24 -> with macro -32768, without -32768. Lo = 2^24-1 is 25-bit max, so use Y_W=25, LO_SHIFT=0 build instead: 0x0FFFFFF -> sat 32767 vs wrap -1.
- hi_out_ready=0, 17 strobes with Hi = 1..17 -> hi_level = 16, hi_overflow = 1 after the 17th; then ready=1 pops 1..16 in order, hi_out_valid drops after 16.
- FIFO full, strobe with ready=1 in the same cycle -> level stays 16, overflow stays 0, head advances; next hi_out = 2.
- Assert rstn low mid-group (after 3 strobes) with FIFO level 3 -> all outputs 0 and level 0; the next 6 strobes form a fresh group with no stale data.
